// File: rtl/seg_pkg.sv
// Shared constants and FSM state type for the BCD digit feeder and the
// 7-segment display path it drives.
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int BCD_W      = NUM_DIGITS * DIGIT_W;
  localparam int MAX_VAL    = 9999;
  localparam logic [DIGIT_W-1:0] ERR_DIGIT = 4'hE;

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_e;
endpackage

// File: rtl/bcd_digit_feeder_add3.sv
// bcd_add3_stage: combinational double-dabble correction. Every BCD nibble
// that is >= 5 gets +3 so the following left shift carries correctly into
// the next decimal digit.
//   bcd_i : BCD field before correction
//   bcd_o : BCD field after per-nibble add-3
module bcd_add3_stage
  import seg_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [BCD_W-1:0] bcd_o
);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
    logic [DIGIT_W-1:0] nib;
    assign nib = bcd_i[g*DIGIT_W +: DIGIT_W];
    assign bcd_o[g*DIGIT_W +: DIGIT_W] = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

endmodule

// File: rtl/bcd_digit_feeder.sv
// bcd_digit_feeder: sequential binary-to-BCD converter (shift-add-3, one
// shift per clock) feeding a 4-digit multiplexed 7-segment driver. Digit and
// dot outputs are registers that update all at once when a conversion ends,
// so the display never sees partial results.
//   clk, rst_n        : clock, async active-low reset
//   start, bin, dot_in: conversion request, value, decimal-point flags
//   val3..val0        : thousands..units digits
//   dot3..dot0        : decimal-point flags, latched with the digits
//   busy, done, ovf   : in-progress, one-cycle result strobe, bin > MAX_VAL
// Build option: define BCD_FEEDER_SATURATE_EN to show 9999 on overflow
// instead of EEEE.
module bcd_digit_feeder
  import seg_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = seg_pkg::MAX_VAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  input  logic [3:0]       dot_in,
  output logic [3:0]       val3,
  output logic [3:0]       val2,
  output logic [3:0]       val1,
  output logic [3:0]       val0,
  output logic             dot3,
  output logic             dot2,
  output logic             dot1,
  output logic             dot0,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W) + 1;
  localparam logic [31:0] MAX_U = 32'(MAX_VAL);

`ifdef BCD_FEEDER_SATURATE_EN
  localparam logic [BCD_W-1:0] OVF_DIGITS = {NUM_DIGITS{4'd9}};
`else
  localparam logic [BCD_W-1:0] OVF_DIGITS = {NUM_DIGITS{ERR_DIGIT}};
`endif

  state_e             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         dot_hold_q, dot_hold_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic [3:0]         dots_q, dots_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_adj;

  bcd_add3_stage u_add3 (
    .bcd_i (sr_q[SR_W-1 -: BCD_W]),
    .bcd_o (bcd_adj)
  );

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    dot_hold_d = dot_hold_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    dots_d     = dots_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d       = {{BCD_W{1'b0}}, bin};
          dot_hold_d = dot_in;
          ovf_pend_d = (32'(bin) > MAX_U);
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        // correction and shift happen in the same cycle
        sr_d  = {bcd_adj[BCD_W-2:0], sr_q[BIN_W-1:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = LATCH;
      end
      LATCH: begin
        digits_d = ovf_pend_q ? OVF_DIGITS : sr_q[SR_W-1 -: BCD_W];
        dots_d   = dot_hold_q;
        ovf_d    = ovf_pend_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      dot_hold_q <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      dots_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      dot_hold_q <= dot_hold_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
      dots_q     <= dots_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign {val3, val2, val1, val0} = digits_q;
  assign {dot3, dot2, dot1, dot0} = dots_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_digit_feeder.sv
// Scoreboard bench for bcd_digit_feeder: stimulus pushes hand-computed
// results, a negedge monitor pops them on done and checks value + latency,
// and checks the outputs hold the previous result while busy.
module tb_bcd_digit_feeder;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [13:0] bin;
  logic [3:0]  dot_in;
  logic [3:0]  val3, val2, val1, val0;
  logic        dot3, dot2, dot1, dot0, busy, done, ovf;

  bcd_digit_feeder #(.BIN_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin), .dot_in(dot_in),
    .val3(val3), .val2(val2), .val1(val1), .val0(val0),
    .dot3(dot3), .dot2(dot2), .dot1(dot1), .dot0(dot0),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dots;
    logic        ovf;
    int          cyc;
  } exp_t;

`ifdef BCD_FEEDER_SATURATE_EN
  localparam logic [15:0] OVF_EXP = 16'h9999;
`else
  localparam logic [15:0] OVF_EXP = 16'hEEEE;
`endif

  exp_t        sb[$];
  exp_t        cur;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          ndone = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({val3, val2, val1, val0, dot3, dot2, dot1, dot0, ovf});
  endfunction

  function automatic logic [63:0] pack(input exp_t e);
    return 64'({e.dig, e.dots, e.ovf});
  endfunction

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 64'(ndone), 64'(-1));
          end else begin
            e = sb.pop_front();
            chk("result", outs(), pack(e));
            chk("latency", 64'(cyc), 64'(e.cyc));
            chk("busy_at_done", 64'(busy), 64'(0));
            cur = e;
          end
          ndone++;
        end else if (busy) begin
          chk("hold", outs(), pack(cur));
        end
      end
    end
  end

  // called at a negedge; start is sampled on the next posedge
  task automatic issue(input logic [13:0] b, input logic [3:0] d,
                       input logic [15:0] dig, input logic ov);
    exp_t e;
    e.dig = dig; e.dots = d; e.ovf = ov; e.cyc = cyc + 16;
    sb.push_back(e);
    start = 1'b1; bin = b; dot_in = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      n++;
      if (n > 40) begin
        chk("done_timeout", 64'(n), 64'(0));
        break;
      end
    end
  endtask

  initial begin
    cur = '{dig: 16'h0, dots: 4'h0, ovf: 1'b0, cyc: 0};
    rst_n = 1'b0; start = 1'b0; bin = '0; dot_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 64'(0));
    chk("reset_busy_done", 64'({busy, done}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic conversion
    issue(14'd1234, 4'b0100, 16'h1234, 1'b0);
    wait_done();

    // back-to-back, second start in the done cycle
    @(negedge clk);
    issue(14'd0, 4'b0001, 16'h0000, 1'b0);
    wait_done();
    issue(14'd9999, 4'b1000, 16'h9999, 1'b0);
    wait_done();

    // overflow then recovery
    @(negedge clk);
    issue(14'd10000, 4'b0011, OVF_EXP, 1'b1);
    wait_done();
    repeat (2) @(negedge clk);
    issue(14'd42, 4'b0000, 16'h0042, 1'b0);
    wait_done();

    // start while busy is ignored
    @(negedge clk);
    issue(14'd5678, 4'b0110, 16'h5678, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; bin = 14'd1111; dot_in = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);

    // reset mid-conversion discards the in-flight result
    start = 1'b1; bin = 14'd4321; dot_in = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outs", outs(), 64'(0));
    chk("midreset_busy_done", 64'({busy, done}), 64'(0));
    cur = '{dig: 16'h0, dots: 4'h0, ovf: 1'b0, cyc: 0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(14'd4321, 4'b1010, 16'h4321, 1'b0);
    wait_done();

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    chk("done_count", 64'(ndone), 64'(7));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_digit_feeder.md
Name: bcd_digit_feeder

Overview:
- Sequential binary-to-BCD converter using the double-dabble (shift-add-3) method, one shift per clock.
- Converts a 14-bit unsigned value into four BCD digits plus four decimal-point flags.
- Sits directly upstream of the 4-digit multiplexed 7-segment driver. Drives its val3..val0 / dot3..dot0 inputs from registers that update atomically once per conversion.

Parameters:
- BIN_W, 14, width of binary input. Legal range 4..14. Overflow is only reachable at 14.
- MAX_VAL, 9999, largest value representable on four digits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request conversion of bin; sampled only in IDLE
- bin  in  BIN_W  unsigned binary value; captured on accepted start
- dot_in  in  4  decimal-point flags [3]=dot3..[0]=dot0; captured on accepted start
- val3  out  4  thousands digit (registered)
- val2  out  4  hundreds digit (registered)
- val1  out  4  tens digit (registered)
- val0  out  4  units digit (registered)
- dot3..dot0  out  1 each  decimal-point flags, registered alongside digits
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse when new digits are valid
- ovf  out  1  sticky per conversion: last captured bin > MAX_VAL

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: all val*/dot*/busy/done/ovf = 0; FSM = IDLE; internal shift register and counter = 0.
- FSM states: IDLE, CONV, LATCH.
- IDLE:
  - On start=1 at edge E0: capture bin into shift register (BCD field cleared), dot_in into a dot holding reg, and compute ovf_pending = (bin > MAX_VAL).
  - Set cnt = 0, busy = 1, go to CONV.
- CONV, each edge:
  - For each of the 4 BCD nibbles, add 3 if nibble >= 5.
  - Then shift the {bcd, bin} register left by 1 and increment cnt.
  - Add-3 and shift form one combinational step per cycle.
  - When the step with cnt == BIN_W-1 completes, go to LATCH.
- LATCH, one edge:
  - Load val3..val0 from the BCD nibbles, dot3..dot0 from the holding reg, ovf from ovf_pending.
  - done = 1 for exactly this next cycle; busy = 0; go to IDLE.
- Latency: done is high in the cycle following edge E0+BIN_W+1, i.e. 15 clocks after start for BIN_W=14. Latency is fixed and independent of value.
- Outputs hold their previous value throughout CONV. The downstream display never sees partial digits.
- start while busy=1 (CONV or LATCH) is ignored, not queued.
- start asserted in the cycle done=1 (FSM already IDLE) is accepted.
- Overflow (bin > 9999, only possible for BIN_W=14): conversion still runs for uniform latency. At LATCH all four digits = 4'hE (downstream shows "EEEE"), dots = captured flags, ovf = 1.
- ovf clears on the next non-overflowing conversion.
- rst_n low mid-conversion: immediate return to reset values. The in-flight conversion is discarded and no done pulse is generated.
- Width: BCD field 16 bits, total shift register 16+BIN_W bits. cnt width = clog2(BIN_W)+1.

Optional Feature:
- Macro: BCD_FEEDER_SATURATE_EN.
- Defined: an overflowing input is clamped. At LATCH the digits are 9,9,9,9 and ovf = 1.
- Undefined: overflow behaviour is "EEEE" as specified above.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package seg_pkg:
  - Constants NUM_DIGITS=4, DIGIT_W=4, MAX_VAL=9999, ERR_DIGIT=4'hE.
  - FSM state typedef {IDLE, CONV, LATCH}.
- Sub-module bcd_add3_stage: combinational. Takes the 16-bit BCD field, returns it with per-nibble add-3 applied. Instantiated once inside the shift loop.

Test Plan:
- Reset, then start with bin=1234, dot_in=4'b0100 -> done exactly 15 clocks later; val3..0 = 1,2,3,4; dot2=1, others 0; ovf=0.
- bin=0, then bin=9999 back-to-back, second start in the done cycle -> 0,0,0,0, then 9,9,9,9 with its done 15 clocks after the second start.
- bin=10000 -> default build: E,E,E,E with ovf=1; SATURATE build: 9,9,9,9 with ovf=1. A following conversion of 42 -> 0,0,4,2 with ovf=0.
- Start 5678, pulse start with 1111 at clock 5 -> second start ignored; result 5,6,7,8; exactly one done pulse.
- Start 4321, assert rst_n=0 at clock 7 -> all outputs 0 immediately, no done; a fresh start of 4321 after release -> 4,3,2,1 at 15 clocks.
- Check outputs are unchanged throughout every CONV cycle, i.e. the previous digits are held until done.
